// File: rtl/alu_share_arbiter_pkg.sv
// ============================================================================
// Module      : alu_share_arbiter_pkg
// Description : Shared ALU control codes and arbiter constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_arbiter_pkg;

  localparam int ARB_XLEN = 32;
  localparam int ARB_NREQ = 2;
  localparam int ARB_ID_W = 1;

  localparam logic [4:0] ALU_ADD     = 5'h00;
  localparam logic [4:0] ALU_SUB     = 5'h01;
  localparam logic [4:0] ALU_AND     = 5'h02;
  localparam logic [4:0] ALU_OR      = 5'h03;
  localparam logic [4:0] ALU_XOR     = 5'h04;
  localparam logic [4:0] ALU_SLL     = 5'h05;
  localparam logic [4:0] ALU_SRL_SRA = 5'h06;
  localparam logic [4:0] ALU_SLT     = 5'h07;
  localparam logic [4:0] ALU_SLTU    = 5'h08;

  typedef logic [ARB_ID_W-1:0] arb_id_t;

  function automatic arb_id_t other_id(input arb_id_t id);
    return ~id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rsp_slot.sv
// ============================================================================
// Module      : alu_rsp_slot
// Description : One-deep valid/ready holding register for an ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rsp_slot #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_data,
  input  logic            rsp_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;

  // The arbiter never loads an occupied slot, so load and drain cannot collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (r_valid && rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU by two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN       = ARB_XLEN,
  parameter int PRIO_RESET = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [4:0]      req0_ctl,
  input  logic [6:0]      req0_funct7,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [4:0]      req1_ctl,
  input  logic [6:0]      req1_funct7,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_ctl,
  output logic [6:0]      alu_funct7,
  input  logic [XLEN-1:0] alu_out
);

  localparam arb_id_t c_prio_reset = arb_id_t'(PRIO_RESET);

  logic            r_iss_valid;
  arb_id_t         r_iss_id;
  logic [XLEN-1:0] r_iss_a;
  logic [XLEN-1:0] r_iss_b;
  logic [4:0]      r_iss_ctl;
  logic [6:0]      r_iss_f7;
  arb_id_t         r_prio;

  logic    w_busy0, w_busy1;
  logic    w_elig0, w_elig1;
  logic    w_grant0, w_grant1;
  logic    w_cap0, w_cap1;
  arb_id_t w_gnt_id;

  // A requester is busy from acceptance until its response is drained.
  assign w_busy0 = (r_iss_valid && (r_iss_id == 1'b0)) || rsp0_valid;
  assign w_busy1 = (r_iss_valid && (r_iss_id == 1'b1)) || rsp1_valid;
  assign w_elig0 = req0_valid && !w_busy0 && !rst;
  assign w_elig1 = req1_valid && !w_busy1 && !rst;

  assign w_grant0 = w_elig0 && (!w_elig1 || (r_prio == 1'b0));
  assign w_grant1 = w_elig1 && (!w_elig0 || (r_prio == 1'b1));
  assign w_gnt_id = arb_id_t'(w_grant1);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_id    <= '0;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
      r_iss_ctl   <= '0;
      r_iss_f7    <= '0;
      r_prio      <= c_prio_reset;
    end else if (w_grant0 || w_grant1) begin
      r_iss_valid <= 1'b1;
      r_iss_id    <= w_gnt_id;
      r_iss_a     <= w_grant1 ? req1_a      : req0_a;
      r_iss_b     <= w_grant1 ? req1_b      : req0_b;
      r_iss_ctl   <= w_grant1 ? req1_ctl    : req0_ctl;
      r_iss_f7    <= w_grant1 ? req1_funct7 : req0_funct7;
      r_prio      <= other_id(w_gnt_id);
    end else begin
      r_iss_valid <= 1'b0;
    end
  end

  assign alu_a      = r_iss_a;
  assign alu_b      = r_iss_b;
  assign alu_ctl    = r_iss_ctl;
  assign alu_funct7 = r_iss_f7;

  assign w_cap0 = r_iss_valid && (r_iss_id == 1'b0);
  assign w_cap1 = r_iss_valid && (r_iss_id == 1'b1);

  alu_rsp_slot #(.XLEN(XLEN)) u_rsp0 (
    .clk       (clk),
    .rst       (rst),
    .load      (w_cap0),
    .load_data (alu_out),
    .rsp_ready (rsp0_ready),
    .rsp_valid (rsp0_valid),
    .rsp_data  (rsp0_data)
  );

  alu_rsp_slot #(.XLEN(XLEN)) u_rsp1 (
    .clk       (clk),
    .rst       (rst),
    .load      (w_cap1),
    .load_data (alu_out),
    .rsp_ready (rsp1_ready),
    .rsp_valid (rsp1_valid),
    .rsp_data  (rsp1_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench with a behavioural ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]      req0_ctl, req1_ctl;
  logic [6:0]      req0_funct7, req1_funct7;
  logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [XLEN-1:0] rsp0_data, rsp1_data;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;
  logic [4:0]      alu_ctl;
  logic [6:0]      alu_funct7;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.XLEN(XLEN), .PRIO_RESET(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctl(req0_ctl), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctl(req1_ctl), .req1_funct7(req1_funct7),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_funct7(alu_funct7),
    .alu_out(alu_out)
  );

  // Reference ALU; undefined codes return zero.
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_SLL:  alu_out = alu_a << alu_b[4:0];
      ALU_SRL_SRA: begin
        if (alu_funct7[5]) alu_out = $signed(alu_a) >>> alu_b[4:0];
        else               alu_out = alu_a >> alu_b[4:0];
      end
      ALU_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'b0, alu_a < alu_b};
      default:  alu_out = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [4:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [6:0] f7);
    req0_valid = v; req0_ctl = ctl; req0_a = a; req0_b = b; req0_funct7 = f7;
  endtask

  task automatic set_req1(input logic v, input logic [4:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [6:0] f7);
    req1_valid = v; req1_ctl = ctl; req1_a = a; req1_b = b; req1_funct7 = f7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req0(1'b0, ALU_ADD, 0, 0, 0);
    set_req1(1'b0, ALU_ADD, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Offers one op on port 0 and returns just after the capture edge.
  task automatic issue0(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] f7, output bit ok);
    ok = 1'b0;
    rsp0_ready = 1'b0;
    set_req0(1'b1, ctl, a, b, f7);
    for (int n = 0; n < 10 && !ok; n++) begin
      #1;
      if (req0_ready === 1'b1) ok = 1'b1;
      step();
    end
    req0_valid = 1'b0;
    step();
  endtask

  task automatic drain0();
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b1, ALU_ADD, 1, 2, 0);
    set_req1(1'b1, ALU_ADD, 3, 4, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
    end
    step(); step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b%b want 00", rsp0_valid, rsp1_valid);
    end
    checks++;
    if (alu_a !== 0 || alu_b !== 0 || alu_ctl !== 0 || alu_funct7 !== 0 ||
        rsp0_data !== 0 || rsp1_data !== 0) begin
      errors++; $display("FAIL reset_regs got a=%h b=%h ctl=%h f7=%h d0=%h d1=%h want all 0",
                         alu_a, alu_b, alu_ctl, alu_funct7, rsp0_data, rsp1_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    rsp0_ready = 1'b0;
    set_req0(1'b1, ALU_ADD, 5, 7, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", req0_ready); end
    step();
    checks++;
    if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0 || alu_a !== 5 || alu_b !== 7) begin
      errors++; $display("FAIL single_issue got rdy=%b rv=%b a=%0d b=%0d want 0 0 5 7",
                         req0_ready, rsp0_valid, alu_a, alu_b);
    end
    step();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 12 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL single_rsp got rv=%b d=%0d rdy=%b want 1 12 0",
                         rsp0_valid, rsp0_data, req0_ready);
    end
    req0_valid = 1'b0;
    drain0();
    checks++;
    if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp0_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req0(1'b1, ALU_SUB, 10, 3, 0);
    set_req1(1'b1, ALU_XOR, 32'hF0, 32'hFF, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL contend_first got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || alu_ctl !== ALU_SUB) begin
      errors++; $display("FAIL contend_second got rdy1=%b ctl=%h want 1 %h", req1_ready, alu_ctl, ALU_SUB);
    end
    step();
    req1_valid = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 7) begin
      errors++; $display("FAIL contend_rsp0 got v=%b d=%0d want 1 7", rsp0_valid, rsp0_data);
    end
    step();
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h0F || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL contend_rsp1 got v=%b d=%h v0=%b want 1 0000000f 0",
                         rsp1_valid, rsp1_data, rsp0_valid);
    end
    step();
    // Last grant went to port 1, so port 0 now wins; afterwards port 1 wins.
    set_req0(1'b1, ALU_ADD, 1, 1, 0);
    set_req1(1'b1, ALU_ADD, 2, 2, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL prio_round_a got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step(); step();
    set_req0(1'b1, ALU_ADD, 1, 1, 0);
    set_req1(1'b1, ALU_ADD, 2, 2, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL prio_round_b got %b%b want 01", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$];
    logic [31:0] k;
    int done;
    bit acc;
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    set_req0(1'b1, ALU_ADD, 100, 23, 0);
    step();
    set_req0(1'b1, ALU_ADD, 1, 1, 0);
    k = 1; done = 0;
    for (int c = 0; c < 10; c++) begin
      set_req1(1'b1, ALU_ADD, k, k + 10, 0);
      #1;
      if (c >= 1) begin
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 123) begin
          errors++; $display("FAIL bp_hold c=%0d got v=%b d=%0d want 1 123", c, rsp0_valid, rsp0_data);
        end
      end
      checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready c=%0d got 1 want 0", c); end
      if (rsp1_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || rsp1_data !== exp_q[0]) begin
          errors++; $display("FAIL bp_stream c=%0d got %0d want %0d", c, rsp1_data,
                             (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        done++;
      end
      acc = (req1_ready === 1'b1);
      step();
      if (acc) begin
        exp_q.push_back(2 * k + 10);
        k = k + 1;
      end
    end
    checks++;
    if (done < 3) begin errors++; $display("FAIL bp_throughput got %0d want >=3", done); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    step();
    checks++;
    if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", rsp0_valid); end
    rsp0_ready = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_shifts();
    bit ok;
    logic [4:0]  ctl_t [4] = '{ALU_SRL_SRA, ALU_SRL_SRA, ALU_SLT, ALU_SLTU};
    logic [31:0] a_t   [4] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b_t   [4] = '{32'd4, 32'd4, 32'd1, 32'd1};
    logic [6:0]  f7_t  [4] = '{7'h20, 7'h00, 7'h00, 7'h00};
    logic [31:0] exp_t [4] = '{32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue0(ctl_t[i], a_t[i], b_t[i], f7_t[i], ok);
      checks++;
      if (!ok || rsp0_valid !== 1'b1 || rsp0_data !== exp_t[i]) begin
        errors++; $display("FAIL shift_op%0d got ok=%b v=%b d=%h want 1 1 %h",
                           i, ok, rsp0_valid, rsp0_data, exp_t[i]);
      end
      drain0();
    end
  endtask

  task automatic test_undef();
    bit ok;
    issue0(ALU_ADD, 40, 2, 0, ok);
    checks++;
    if (!ok || rsp0_data !== 42) begin errors++; $display("FAIL undef_pre got ok=%b d=%0d want 1 42", ok, rsp0_data); end
    drain0();
    issue0(5'h1F, 5, 7, 0, ok);
    checks++;
    if (!ok || rsp0_valid !== 1'b1 || rsp0_data !== 0) begin
      errors++; $display("FAIL undef_ctl got ok=%b v=%b d=%h want 1 1 0", ok, rsp0_valid, rsp0_data);
    end
    drain0();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b1, ALU_ADD, 3, 4, 0);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    set_req1(1'b1, ALU_ADD, 9, 9, 0);
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", req1_ready); end
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_rst_drop got rsp_valid=1 want 0"); end
    set_req0(1'b1, ALU_ADD, 20, 22, 0);
    set_req1(1'b1, ALU_ADD, 1, 2, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_prio got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 42) begin
      errors++; $display("FAIL mid_rst_new got v=%b d=%0d want 1 42", rsp0_valid, rsp0_data);
    end
    drain0();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b0, ALU_ADD, 0, 0, 0);
    set_req1(1'b0, ALU_ADD, 0, 0, 0);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_shifts();
    test_undef();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
